// File: rtl/memory_operation_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : memory_operation_pipelined
// Brief    : Single-port byte-maskable RAM with power-up clear sequence and a
//            1- or 2-stage read pipeline with selectable collision policy.
// Revision : 1.0
// ============================================================================
module memory_operation_pipelined #(
    parameter int DATA_SIZE  = 16,
    parameter int ADDRESS    = 4,
    parameter int RD_LATENCY = 1,
    parameter int WR_MODE    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cs,
    input  logic                   write_en,
    input  logic                   read_en,
    input  logic [ADDRESS-1:0]     address_in,
    input  logic [DATA_SIZE-1:0]   data_in,
    input  logic [DATA_SIZE/8-1:0] byte_en,
    output logic [DATA_SIZE-1:0]   data_out,
    output logic                   data_valid,
    output logic                   busy
);

    localparam int                 c_NUM_BYTES = DATA_SIZE / 8;
    localparam int                 c_DEPTH     = 2 ** ADDRESS;
    localparam logic [ADDRESS-1:0] c_LAST_ADDR = '1;
    localparam logic [ADDRESS-1:0] c_ADDR_ONE  = {{(ADDRESS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDRESS-1:0]     r_clr_addr;
    logic [DATA_SIZE-1:0]   r_mem [c_DEPTH];

    logic                   w_busy;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic [DATA_SIZE-1:0]   w_old;
    logic [DATA_SIZE-1:0]   w_merged;
    logic [DATA_SIZE-1:0]   w_rd_word;

    logic [RD_LATENCY-1:0]  r_pv;
    logic [DATA_SIZE-1:0]   r_pd [RD_LATENCY];
    logic [DATA_SIZE-1:0]   r_dout;
    logic                   r_dv;

    assign w_busy   = (r_state == S_CLEAR);
    assign w_wr_acc = cs & write_en & ~w_busy;
    assign w_rd_acc = cs & read_en & ~w_busy;
    assign w_old    = r_mem[address_in];

    generate
        for (genvar b = 0; b < c_NUM_BYTES; b++) begin : g_byte
            assign w_merged[8*b +: 8] = byte_en[b] ? data_in[8*b +: 8] : w_old[8*b +: 8];
        end
    endgenerate

    // Write-first returns the merged word only when a write lands on the same edge.
    assign w_rd_word = ((WR_MODE != 0) && w_wr_acc) ? w_merged : w_old;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_busy) begin
                r_clr_addr <= r_clr_addr + c_ADDR_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_addr == c_LAST_ADDR) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Storage carries no reset; the clear sequence provides the zero fill.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clr_addr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[address_in] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv   <= '0;
            r_dout <= '0;
            r_dv   <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_pd[0] <= w_rd_word;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
            r_dv <= r_pv[RD_LATENCY-1];
            if (r_pv[RD_LATENCY-1]) begin
                r_dout <= r_pd[RD_LATENCY-1];
            end
        end
    end

    assign data_out   = r_dout;
    assign data_valid = r_dv;
    assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_memory_operation_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_operation_pipelined
// Brief    : Runs all four latency/collision-policy variants side by side
//            against one behavioural memory model, plus directed scenarios.
// Revision : 1.0
// ============================================================================
module tb_memory_operation_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs, write_en, read_en;
    logic [3:0]  address_in;
    logic [15:0] data_in;
    logic [1:0]  byte_en;
    logic [15:0] dout [4];
    logic [3:0]  dv;
    logic [3:0]  busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Variant k: RD_LATENCY = 1 + k/2, WR_MODE = k%2.
    generate
        for (genvar k = 0; k < 4; k++) begin : g_dut
            memory_operation_pipelined #(
                .DATA_SIZE (16),
                .ADDRESS   (4),
                .RD_LATENCY(1 + k / 2),
                .WR_MODE   (k % 2)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .cs        (cs),
                .write_en  (write_en),
                .read_en   (read_en),
                .address_in(address_in),
                .data_in   (data_in),
                .byte_en   (byte_en),
                .data_out  (dout[k]),
                .data_valid(dv[k]),
                .busy      (busy[k])
            );
        end
    endgenerate

    // Behavioural model: memory contents, remaining clear edges, and per-variant
    // expected completions indexed by completion edge number modulo 4.
    logic [15:0] m_mem [16];
    int          clr_left = 16;
    int          cyc = 0;
    logic        exp_v [4][4];
    logic [15:0] exp_d [4][4];
    logic [15:0] last_d [4];
    int          pulse_cnt [4];

    task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        clr_left = 16;
        for (int a = 0; a < 16; a++) m_mem[a] = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            last_d[k] = 16'h0000;
            for (int s = 0; s < 4; s++) begin
                exp_v[k][s] = 1'b0;
                exp_d[k][s] = 16'h0000;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) pulse_cnt[k] = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cyc++;
                if (clr_left > 0) begin
                    clr_left--;
                end else if (cs) begin
                    logic [15:0] old_w, new_w;
                    old_w = m_mem[address_in];
                    new_w = old_w;
                    if (byte_en[0]) new_w[7:0]  = data_in[7:0];
                    if (byte_en[1]) new_w[15:8] = data_in[15:8];
                    if (write_en) m_mem[address_in] = new_w;
                    if (read_en) begin
                        for (int k = 0; k < 4; k++) begin
                            int slot;
                            slot = (cyc + 1 + k / 2) % 4;
                            exp_v[k][slot] = 1'b1;
                            exp_d[k][slot] = ((k % 2 == 1) && write_en) ? new_w : old_w;
                        end
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, every variant.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                logic ev, eb;
                int   slot;
                slot = cyc % 4;
                if (!rst_n) begin
                    ev = 1'b0;
                    eb = 1'b1;
                    last_d[k] = 16'h0000;
                end else begin
                    ev = exp_v[k][slot];
                    eb = (clr_left != 0);
                    if (ev) last_d[k] = exp_d[k][slot];
                    exp_v[k][slot] = 1'b0;
                end
                if (dv[k]) pulse_cnt[k]++;
                chk("data_valid", k, {15'd0, dv[k]}, {15'd0, ev});
                chk("data_out", k, dout[k], last_d[k]);
                chk("busy", k, {15'd0, busy[k]}, {15'd0, eb});
            end
        end
    end

    task automatic drv(input logic c, input logic we, input logic re, input logic [3:0] a,
                       input logic [15:0] d, input logic [1:0] be);
        cs = c; write_en = we; read_en = re; address_in = a; data_in = d; byte_en = be;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);
    endtask

    // Asserts reset immediately, checks outputs asynchronously, releases;
    // returns one clear edge after release.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_dout", k, dout[k], 16'h0000);
            chk("rst_dv", k, {15'd0, dv[k]}, 16'h0000);
            chk("rst_busy", k, {15'd0, busy[k]}, 16'h0001);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic check_busy_window();
        idle(14);
        for (int k = 0; k < 4; k++) chk("busy_edge15", k, {15'd0, busy[k]}, 16'h0001);
        idle(1);
        for (int k = 0; k < 4; k++) chk("busy_edge16", k, {15'd0, busy[k]}, 16'h0000);
    endtask

    initial begin
        int p0 [4];
        cs = 0; write_en = 0; read_en = 0; address_in = 0; data_in = 0; byte_en = 0;

        // Reset release, clear window, read all addresses as zero.
        do_reset();
        check_busy_window();
        for (int k = 0; k < 4; k++) p0[k] = pulse_cnt[k];
        for (int a = 0; a < 16; a++) drv(1'b1, 1'b0, 1'b1, 4'(a), 16'h0000, 2'b00);
        idle(3);
        for (int k = 0; k < 4; k++) chk("sweep_pulses", k, 16'(pulse_cnt[k] - p0[k]), 16'd16);

        // Byte-masked write merge.
        drv(1'b1, 1'b1, 1'b0, 4'd3, 16'hA5C3, 2'b11);
        drv(1'b1, 1'b1, 1'b0, 4'd3, 16'hFFFF, 2'b01);
        drv(1'b1, 1'b0, 1'b1, 4'd3, 16'h0000, 2'b00);
        idle(3);
        for (int k = 0; k < 4; k++) chk("byte_merge", k, dout[k], 16'hA5FF);

        // Back-to-back reads; latency-2 variant pinned cycle by cycle.
        drv(1'b1, 1'b1, 1'b0, 4'd1, 16'h0011, 2'b11);
        drv(1'b1, 1'b1, 1'b0, 4'd2, 16'h0022, 2'b11);
        drv(1'b1, 1'b1, 1'b0, 4'd3, 16'h0033, 2'b11);
        drv(1'b1, 1'b0, 1'b1, 4'd1, 16'h0000, 2'b00);
        drv(1'b1, 1'b0, 1'b1, 4'd2, 16'h0000, 2'b00);
        for (int k = 2; k < 4; k++) chk("lat2_early", k, {15'd0, dv[k]}, 16'h0000);
        drv(1'b1, 1'b0, 1'b1, 4'd3, 16'h0000, 2'b00);
        for (int k = 2; k < 4; k++) chk("lat2_d0", k, {dv[k], dout[k][14:0]}, 16'h8011);
        idle(1);
        for (int k = 2; k < 4; k++) chk("lat2_d1", k, {dv[k], dout[k][14:0]}, 16'h8022);
        idle(1);
        for (int k = 2; k < 4; k++) chk("lat2_d2", k, {dv[k], dout[k][14:0]}, 16'h8033);
        idle(1);
        for (int k = 2; k < 4; k++) chk("lat2_end", k, {dv[k], dout[k][14:0]}, 16'h0033);

        // Same-edge write and read collision.
        drv(1'b1, 1'b1, 1'b0, 4'd5, 16'hBEEF, 2'b11);
        drv(1'b1, 1'b1, 1'b1, 4'd5, 16'h1234, 2'b11);
        idle(3);
        for (int k = 0; k < 4; k++) chk("collide", k, dout[k], (k % 2 == 1) ? 16'h1234 : 16'hBEEF);
        drv(1'b1, 1'b0, 1'b1, 4'd5, 16'h0000, 2'b00);
        idle(3);
        for (int k = 0; k < 4; k++) chk("after_collide", k, dout[k], 16'h1234);

        // Requests during clear are dropped.
        drv(1'b1, 1'b1, 1'b0, 4'd6, 16'h7777, 2'b11);
        do_reset();
        for (int k = 0; k < 4; k++) p0[k] = pulse_cnt[k];
        drv(1'b1, 1'b1, 1'b1, 4'd6, 16'h5555, 2'b11);
        idle(14);
        for (int k = 0; k < 4; k++) chk("clear_drop", k, 16'(pulse_cnt[k] - p0[k]), 16'd0);
        drv(1'b1, 1'b0, 1'b1, 4'd6, 16'h0000, 2'b00);
        idle(3);
        for (int k = 0; k < 4; k++) begin
            chk("clear_zero", k, dout[k], 16'h0000);
            chk("clear_pulse", k, 16'(pulse_cnt[k] - p0[k]), 16'd1);
        end

        // Reset at clear step 7, then a read lost to reset.
        do_reset();
        idle(6);
        do_reset();
        check_busy_window();
        drv(1'b1, 1'b1, 1'b0, 4'd2, 16'h9999, 2'b11);
        for (int k = 0; k < 4; k++) p0[k] = pulse_cnt[k];
        drv(1'b1, 1'b0, 1'b1, 4'd2, 16'h0000, 2'b00);
        do_reset();
        check_busy_window();
        idle(2);
        for (int k = 0; k < 4; k++) chk("lost_read", k, 16'(pulse_cnt[k] - p0[k]), 16'd0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drv(($urandom % 4) != 0, $urandom % 2 == 1, $urandom % 2 == 1,
                4'($urandom % 16), 16'($urandom), 2'($urandom % 4));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
